dip8_48_block_checker: RTL
==========================

Name: dip8_48_block_checker

Overview:
- Receive-side consumer of the 8-bit diagonal interleaved parity (DIP8) over 48-bit words.
- Accumulates per-word DIP8 across a fixed-length block of 48-bit words and compares the result with the parity byte carried on the block's last word.
- Reports pass/fail per block, framing violations, and saturating statistics.
- Sits after the lane deframer, ahead of link-health/retrain logic.

Parameters:
- BLOCK_WORDS, 64, words per block including sop and last words; legal range 1..65535.
- CNT_W, 16, width of the saturating error and block statistics counters.

Ports:
- clk  in  1  single clock for all logic
- arst_n  in  1  asynchronous active-low reset
- din  in  48  data word
- din_valid  in  1  din and qualifiers valid this cycle; no backpressure
- din_sop  in  1  first word of block (qualified by din_valid)
- din_last  in  1  last word of block (qualified by din_valid)
- din_par  in  8  received block DIP8, meaningful only on a last word
- clr_stat  in  1  synchronous clear of err_cnt, blk_cnt, sticky_err
- res_valid  out  1  one-cycle pulse: block compare result available
- res_err  out  1  with res_valid: 1 = parity mismatch
- res_par_calc  out  8  computed block DIP8, held until next res_valid
- res_par_rx  out  8  received din_par, held until next res_valid
- frame_err  out  1  one-cycle pulse: framing violation
- err_cnt  out  CNT_W  saturating count of mismatched blocks
- blk_cnt  out  CNT_W  saturating count of compared blocks
- sticky_err  out  1  set on any mismatch or frame_err; cleared only by clr_stat or reset

Behaviour:
- Reset (arst_n low, asynchronous): all outputs 0; accumulator 0; word count 0; state IDLE.
- Word parity P(d):
  - Bit i = 8r+c (r = i/8, c = i%8) contributes to p[7 - ((r - c) mod 8)].
  - Each p bit is the XOR of 6 data bits.
  - Examples: P(48'h1) = 8'h80; P(48'h2) = 8'h01; P(all ones) = 8'h00.
- States:
  - IDLE: waiting for sop.
  - IN_BLK: accumulating. Accumulator acc[7:0] and word count wcnt[15:0].
- Accepted word with sop=1 (either state):
  - acc <= P(din); wcnt <= 1; go to IN_BLK.
  - If already in IN_BLK, the previous block is abandoned and frame_err pulses.
  - The new block proceeds normally.
- Accepted word with sop=0 in IN_BLK: acc <= acc ^ P(din); wcnt <= wcnt + 1.
- Accepted word with sop=0 in IDLE: word dropped; frame_err pulses; state unchanged.
- Word with last=1 (including sop=last=1): compute final = acc_next and n = wcnt_next.
  - If n == BLOCK_WORDS:
    - Next cycle: res_valid=1; res_err = (final != din_par); res_par_calc = final; res_par_rx = din_par.
    - blk_cnt increments; err_cnt increments if res_err.
  - Otherwise: frame_err pulses next cycle; no res_valid; counters unchanged.
  - Either way, go to IDLE.
- Overrun: a non-last word making wcnt_next == BLOCK_WORDS → frame_err pulses next cycle; go to IDLE; block discarded.
- Latency: exactly 1 cycle from the accepted last word to res_valid/frame_err. Back-to-back blocks are supported with zero idle cycles.
- din_valid=0: no state change; sop/last/par ignored.
- Counters saturate at all-ones.
- clr_stat coincident with an increment: the clear wins, so the counter reads 0. sticky_err is also cleared even if an error occurs the same cycle.
- frame_err and res_valid are never both asserted in the same cycle.
- Reset mid-block: block discarded; no result or frame_err emitted afterwards.

Test Plan:
- BLOCK_WORDS=2; words 48'h1 (sop), 48'h2 (last, din_par=8'h81) → one cycle later res_valid=1, res_err=0, res_par_calc=8'h81; blk_cnt=1, err_cnt=0.
- Same block with din_par=8'h80 → res_err=1, err_cnt=1, sticky_err=1; then clr_stat=1 → counters and sticky read 0 next cycle.
- BLOCK_WORDS=1; continuous all-ones words, each sop=last=1, din_par=8'h00, for 100 cycles → 100 res_valid pulses, all res_err=0, blk_cnt=100.
- BLOCK_WORDS=4; sop, word, then new sop mid-block, followed by 3 words with last on the third → frame_err pulse at the second sop; second block compared normally.
- BLOCK_WORDS=4; last on word 3 → frame_err, no res_valid. Separately, 4 words with no last → frame_err after word 4; a following non-sop word → another frame_err.
- CNT_W=2; 5 mismatched blocks → err_cnt saturates at 3. Assert arst_n low mid-block → all outputs 0 immediately; no stray pulses after release.

Source files
------------

// File: rtl/dip8_48_block_checker.sv
// DIP8 block checker: accumulates per-word diagonal interleaved parity over a
// fixed-length block of 48-bit words and compares it with the parity byte
// carried on the block's last word. Flags framing violations and keeps
// saturating pass/fail statistics.
module dip8_48_block_checker #(
   parameter int unsigned BLOCK_WORDS = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic [47:0]       din,
   input  logic              din_valid,
   input  logic              din_sop,
   input  logic              din_last,
   input  logic [7:0]        din_par,
   input  logic              clr_stat,
   output logic              res_valid,
   output logic              res_err,
   output logic [7:0]        res_par_calc,
   output logic [7:0]        res_par_rx,
   output logic              frame_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  blk_cnt,
   output logic              sticky_err
);

   localparam int unsigned DW  = 48;
   localparam int unsigned PW  = 8;
   localparam int unsigned WCW = 16;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] IN_BLK = 1'b1;

   localparam logic [WCW-1:0] BLK_LEN = WCW'(BLOCK_WORDS);

   // Bit i = 8r+c of the word folds into parity bit 7 - ((r - c) mod 8).
   function automatic logic [PW-1:0] dip8(input logic [DW-1:0] d);
      logic [PW-1:0] p;
      int unsigned   r;
      int unsigned   c;
      p = '0;
      for (int unsigned i = 0; i < DW; i++) begin
         r = i / 8;
         c = i % 8;
         p[3'(7 - ((r + 8 - c) % 8))] = p[3'(7 - ((r + 8 - c) % 8))] ^ d[i];
      end
      return p;
   endfunction

   logic [0:0]       state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             res_valid_q, res_valid_d;
   logic             res_err_q, res_err_d;
   logic [PW-1:0]    res_par_calc_q, res_par_calc_d;
   logic [PW-1:0]    res_par_rx_q, res_par_rx_d;
   logic             frame_err_q, frame_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
   logic             sticky_q, sticky_d;

   logic [PW-1:0]    word_par;
   logic [PW-1:0]    acc_nx;
   logic [WCW-1:0]   wcnt_nx;
   logic             mismatch;

   // State register and registered outputs.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q        <= IDLE;
         acc_q          <= '0;
         wcnt_q         <= '0;
         res_valid_q    <= 1'b0;
         res_err_q      <= 1'b0;
         res_par_calc_q <= '0;
         res_par_rx_q   <= '0;
         frame_err_q    <= 1'b0;
         err_cnt_q      <= '0;
         blk_cnt_q      <= '0;
         sticky_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         wcnt_q         <= wcnt_d;
         res_valid_q    <= res_valid_d;
         res_err_q      <= res_err_d;
         res_par_calc_q <= res_par_calc_d;
         res_par_rx_q   <= res_par_rx_d;
         frame_err_q    <= frame_err_d;
         err_cnt_q      <= err_cnt_d;
         blk_cnt_q      <= blk_cnt_d;
         sticky_q       <= sticky_d;
      end
   end

   // Block framing, accumulation, compare and statistics.
   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      wcnt_d         = wcnt_q;
      res_valid_d    = 1'b0;
      res_err_d      = res_err_q;
      res_par_calc_d = res_par_calc_q;
      res_par_rx_d   = res_par_rx_q;
      frame_err_d    = 1'b0;
      err_cnt_d      = err_cnt_q;
      blk_cnt_d      = blk_cnt_q;
      mismatch       = 1'b0;

      word_par = dip8(din);
      acc_nx   = din_sop ? word_par : (acc_q ^ word_par);
      wcnt_nx  = din_sop ? WCW'(1) : (wcnt_q + WCW'(1));

      if (din_valid) begin
         if (din_sop || (state_q == IN_BLK)) begin
            // A new sop while a block is open abandons the old block.
            if (din_sop && (state_q == IN_BLK)) begin
               frame_err_d = 1'b1;
            end
            acc_d   = acc_nx;
            wcnt_d  = wcnt_nx;
            state_d = IN_BLK;
            if (din_last) begin
               state_d = IDLE;
               if (wcnt_nx == BLK_LEN) begin
                  mismatch       = (acc_nx != din_par);
                  res_valid_d    = 1'b1;
                  res_err_d      = mismatch;
                  res_par_calc_d = acc_nx;
                  res_par_rx_d   = din_par;
                  if (blk_cnt_q != '1) begin
                     blk_cnt_d = blk_cnt_q + CNT_W'(1);
                  end
                  if (mismatch && (err_cnt_q != '1)) begin
                     err_cnt_d = err_cnt_q + CNT_W'(1);
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end else if (wcnt_nx == BLK_LEN) begin
               // Block reached full length without a last marker.
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end
         end else begin
            // Orphan word outside any block.
            frame_err_d = 1'b1;
         end
      end

      sticky_d = sticky_q | frame_err_d | mismatch;

      if (clr_stat) begin
         err_cnt_d = '0;
         blk_cnt_d = '0;
         sticky_d  = 1'b0;
      end
   end

   assign res_valid    = res_valid_q;
   assign res_err      = res_err_q;
   assign res_par_calc = res_par_calc_q;
   assign res_par_rx   = res_par_rx_q;
   assign frame_err    = frame_err_q;
   assign err_cnt      = err_cnt_q;
   assign blk_cnt      = blk_cnt_q;
   assign sticky_err   = sticky_q;

endmodule
